// File: rtl/gray_code_counter.sv
// Up/down counter that registers its binary count and the matching Gray code
// on the same edge. Data outputs tri-state under Enable_In; Boundary_Out never does.
module gray_code_counter #(
  parameter int WIDTH = 32,
  parameter bit WRAP  = 1'b1
) (
  input  logic             Clock_In,
  input  logic             Reset_n_In,
  input  logic             Enable_In,
  input  logic             Clear_In,
  input  logic             Load_In,
  input  logic [WIDTH-1:0] Load_Binary_In,
  input  logic             Count_En_In,
  input  logic             Up_Down_In,
  output logic [WIDTH-1:0] Gray_Data_Out,
  output logic [WIDTH-1:0] Binary_Count_Out,
  output logic             Boundary_Out
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             bnd_q, bnd_d;

  logic count_step;
  logic at_edge;

  always_comb begin
    count_step = Count_En_In && !Clear_In && !Load_In;
    at_edge    = Up_Down_In ? (&bin_q) : (~|bin_q);

    bin_d = bin_q;
    bnd_d = 1'b0;

    if (Clear_In) begin
      bin_d = '0;
    end else if (Load_In) begin
      bin_d = Load_Binary_In;
    end else if (Count_En_In) begin
      bnd_d = at_edge;
      // In saturate mode a step off the end of the range is dropped entirely.
      if (!(at_edge && !WRAP)) begin
        bin_d = Up_Down_In ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
      end
    end

    // Encode from the next value so gray_q and bin_q always describe the same count.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      bin_q  <= '0;
      gray_q <= '0;
      bnd_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      bnd_q  <= bnd_d;
    end
  end

  assign Gray_Data_Out    = Enable_In ? gray_q : {WIDTH{1'bz}};
  assign Binary_Count_Out = Enable_In ? bin_q  : {WIDTH{1'bz}};
  assign Boundary_Out     = bnd_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: 4-bit wrap and saturate instances for directed cases,
// 32-bit wrap instance for a random soak, all compared against a behavioural model.
module tb_gray_code_counter;

  logic clk;
  logic rst_n;

  // shared stimulus for the two 4-bit instances
  logic       en, clr, ld, cen, up;
  logic [3:0] ldv;
  // stimulus for the 32-bit instance
  logic        en_w, clr_w, ld_w, cen_w, up_w;
  logic [31:0] ldv_w;

  wire [3:0]  gray_a, bin_a, gray_s, bin_s;
  wire [31:0] gray_w, bin_w;
  wire        bnd_a, bnd_s, bnd_w;

  int n_checks = 0;
  int n_fail   = 0;

  gray_code_counter #(.WIDTH(4), .WRAP(1'b1)) dut_a (
    .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en), .Clear_In(clr),
    .Load_In(ld), .Load_Binary_In(ldv), .Count_En_In(cen), .Up_Down_In(up),
    .Gray_Data_Out(gray_a), .Binary_Count_Out(bin_a), .Boundary_Out(bnd_a)
  );

  gray_code_counter #(.WIDTH(4), .WRAP(1'b0)) dut_s (
    .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en), .Clear_In(clr),
    .Load_In(ld), .Load_Binary_In(ldv), .Count_En_In(cen), .Up_Down_In(up),
    .Gray_Data_Out(gray_s), .Binary_Count_Out(bin_s), .Boundary_Out(bnd_s)
  );

  gray_code_counter #(.WIDTH(32), .WRAP(1'b1)) dut_w (
    .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en_w), .Clear_In(clr_w),
    .Load_In(ld_w), .Load_Binary_In(ldv_w), .Count_En_In(cen_w), .Up_Down_In(up_w),
    .Gray_Data_Out(gray_w), .Binary_Count_Out(bin_w), .Boundary_Out(bnd_w)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] gray_of(input logic [63:0] b);
    logic [63:0] g;
    g = 64'd0;
    for (int i = 0; i < 63; i++) g[i] = b[i] ^ b[i+1];
    g[63] = b[63];
    return g;
  endfunction

  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [63:0] nxt(input int w, input bit wrap, input logic [63:0] cur,
                                      input bit c, input bit l, input logic [63:0] v,
                                      input bit ce, input bit u);
    logic [63:0] top;
    top = (64'd1 << w) - 64'd1;
    if (c) return 64'd0;
    if (l) return v;
    if (!ce) return cur;
    if (u) return (cur == top) ? (wrap ? 64'd0 : top) : cur + 64'd1;
    return (cur == 64'd0) ? (wrap ? top : 64'd0) : cur - 64'd1;
  endfunction

  function automatic bit is_bnd(input int w, input logic [63:0] cur, input bit c,
                                input bit l, input bit ce, input bit u);
    logic [63:0] top;
    top = (64'd1 << w) - 64'd1;
    return ce && !c && !l && (u ? (cur == top) : (cur == 64'd0));
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] m_bin_a, m_bin_s, m_bin_w;
  logic        m_bnd_a, m_bnd_s, m_bnd_w, m_step_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bin_a <= 64'd0; m_bin_s <= 64'd0; m_bin_w <= 64'd0;
      m_bnd_a <= 1'b0;  m_bnd_s <= 1'b0;  m_bnd_w <= 1'b0;
      m_step_w <= 1'b0;
    end else begin
      m_bin_a <= nxt(4, 1'b1, m_bin_a, clr, ld, {60'd0, ldv}, cen, up);
      m_bin_s <= nxt(4, 1'b0, m_bin_s, clr, ld, {60'd0, ldv}, cen, up);
      m_bin_w <= nxt(32, 1'b1, m_bin_w, clr_w, ld_w, {32'd0, ldv_w}, cen_w, up_w);
      m_bnd_a <= is_bnd(4, m_bin_a, clr, ld, cen, up);
      m_bnd_s <= is_bnd(4, m_bin_s, clr, ld, cen, up);
      m_bnd_w <= is_bnd(32, m_bin_w, clr_w, ld_w, cen_w, up_w);
      m_step_w <= cen_w && !clr_w && !ld_w;
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] prev_g;
  logic        prev_ok = 1'b0;

  always @(negedge clk) begin
    chk("bnd_a", {63'd0, bnd_a}, {63'd0, m_bnd_a});
    chk("bnd_s", {63'd0, bnd_s}, {63'd0, m_bnd_s});
    chk("bnd_w", {63'd0, bnd_w}, {63'd0, m_bnd_w});
    if (en) begin
      chk("bin_a",  {60'd0, bin_a},  m_bin_a);
      chk("gray_a", {60'd0, gray_a}, gray_of(m_bin_a));
      chk("bin_s",  {60'd0, bin_s},  m_bin_s);
      chk("gray_s", {60'd0, gray_s}, gray_of(m_bin_s));
    end
    if (en_w) begin
      chk("bin_w",  {32'd0, bin_w},  m_bin_w);
      chk("gray_w", {32'd0, gray_w}, gray_of(m_bin_w));
      chk("conv_w", {32'd0, gray_to_bin(gray_w)}, {32'd0, bin_w});
      if (rst_n && prev_ok && m_step_w)
        chk("onebit_w", 64'($countones(prev_g ^ gray_w)), 64'd1);
      prev_g  <= gray_w;
      prev_ok <= rst_n;
    end else begin
      prev_ok <= 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic cyc4(input bit c, input bit l, input logic [3:0] v, input bit ce, input bit u);
    clr = c; ld = l; ldv = v; cen = ce; up = u;
    @(posedge clk);
    #2;
  endtask

  logic [3:0] exp_gray_up [6];

  initial begin
    exp_gray_up = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5};
    rst_n = 1'b0;
    en = 1'b1; clr = 1'b0; ld = 1'b0; cen = 1'b0; up = 1'b1; ldv = 4'd0;
    en_w = 1'b1; clr_w = 1'b0; ld_w = 1'b0; cen_w = 1'b0; up_w = 1'b1; ldv_w = 32'd0;

    #1;
    chk("rst_bin_a", {60'd0, bin_a}, 64'd0);
    chk("rst_gray_a", {60'd0, gray_a}, 64'd0);
    chk("rst_bnd_a", {63'd0, bnd_a}, 64'd0);
    chk("rst_bin_w", {32'd0, bin_w}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // count-up sequence from reset
    for (int i = 0; i < 6; i++) begin
      cyc4(0, 0, 4'd0, 1, 1);
      chk("up_bin", {60'd0, bin_a}, 64'(i + 1));
      chk("up_gray", {60'd0, gray_a}, {60'd0, exp_gray_up[i]});
      chk("up_bnd", {63'd0, bnd_a}, 64'd0);
    end

    // wrap up and down
    cyc4(0, 1, 4'd15, 0, 1);
    chk("ld15_gray", {60'd0, gray_a}, 64'd8);
    cyc4(0, 0, 4'd0, 1, 1);
    chk("wrapup_bin", {60'd0, bin_a}, 64'd0);
    chk("wrapup_gray", {60'd0, gray_a}, 64'd0);
    chk("wrapup_bnd", {63'd0, bnd_a}, 64'd1);
    cyc4(0, 0, 4'd0, 0, 1);
    chk("wrapup_bnd_clr", {63'd0, bnd_a}, 64'd0);
    cyc4(0, 0, 4'd0, 1, 0);
    chk("wrapdn_bin", {60'd0, bin_a}, 64'd15);
    chk("wrapdn_gray", {60'd0, gray_a}, 64'd8);
    chk("wrapdn_bnd", {63'd0, bnd_a}, 64'd1);
    cyc4(0, 0, 4'd0, 0, 0);
    chk("wrapdn_bnd_clr", {63'd0, bnd_a}, 64'd0);

    // saturate
    cyc4(0, 1, 4'd15, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc4(0, 0, 4'd0, 1, 1);
      chk("sat_hi_bin", {60'd0, bin_s}, 64'd15);
      chk("sat_hi_gray", {60'd0, gray_s}, 64'd8);
      chk("sat_hi_bnd", {63'd0, bnd_s}, 64'd1);
    end
    cyc4(1, 0, 4'd0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc4(0, 0, 4'd0, 1, 0);
      chk("sat_lo_bin", {60'd0, bin_s}, 64'd0);
      chk("sat_lo_bnd", {63'd0, bnd_s}, 64'd1);
    end
    cyc4(0, 0, 4'd0, 0, 0);
    chk("sat_bnd_clr", {63'd0, bnd_s}, 64'd0);

    // command priority
    cyc4(0, 1, 4'd5, 0, 1);
    cyc4(1, 1, 4'd9, 1, 1);
    chk("prio_clr", {60'd0, bin_a}, 64'd0);
    cyc4(0, 1, 4'd9, 1, 1);
    chk("prio_ld_bin", {60'd0, bin_a}, 64'd9);
    chk("prio_ld_gray", {60'd0, gray_a}, 64'd13);

    // counting continues with outputs disabled
    cyc4(1, 0, 4'd0, 0, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) cyc4(0, 0, 4'd0, 1, 1);
    cyc4(0, 0, 4'd0, 0, 1);
    en = 1'b1;
    #1;
    chk("oe_bin", {60'd0, bin_a}, 64'd3);
    chk("oe_gray", {60'd0, gray_a}, 64'd2);

    // asynchronous reset between edges
    cyc4(0, 0, 4'd0, 1, 1);
    cen = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_bin_a", {60'd0, bin_a}, 64'd0);
    chk("arst_gray_a", {60'd0, gray_a}, 64'd0);
    chk("arst_bnd_a", {63'd0, bnd_a}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    cyc4(0, 0, 4'd0, 1, 1);
    chk("post_rst_bin", {60'd0, bin_a}, 64'd1);
    chk("post_rst_gray", {60'd0, gray_a}, 64'd1);

    // random soak
    for (int n = 0; n < 10000; n++) begin
      clr = ($urandom_range(0, 31) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      ldv = 4'($urandom_range(0, 15));
      cen = ($urandom_range(0, 3) != 0);
      up  = $urandom_range(0, 1);
      en  = ($urandom_range(0, 7) != 0);

      clr_w = ($urandom_range(0, 255) == 0);
      ld_w  = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 4))
        0: ldv_w = 32'd0;
        1: ldv_w = 32'hFFFF_FFFF;
        2: ldv_w = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
        3: ldv_w = 32'($urandom_range(0, 6));
        default: ldv_w = $urandom;
      endcase
      cen_w = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up_w = ~up_w;
      en_w  = ($urandom_range(0, 15) != 0);
      @(posedge clk);
      #2;
    end

    en = 1'b1; en_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
